// File: rtl/i2c_slave.sv
// I2C target endpoint for one 7-bit address: oversampled SCL/SDA, START/STOP
// detection, address/data shifting, ACK generation and open-drain read data.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  logic       SDA,
    input  logic [7:0] tx_data,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addressed,
    output logic       stop_det,
    output logic [2:0] state_out
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_BYTE  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_BYTE  = 3'd5;
    localparam logic [2:0] S_RD_ACK   = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    // Synchronizers reset to the idle-bus level so reset release never fakes a START.
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;

    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic       r_full;
    logic       r_rw;
    logic       r_ack;
    logic       r_oe;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
    logic       r_addressed;
    logic       r_stop_det;

    logic [2:0] w_state_nxt;
    logic [7:0] w_shift_nxt;
    logic [2:0] w_cnt_nxt;
    logic       w_full_nxt;
    logic       w_rw_nxt;
    logic       w_ack_nxt;
    logic       w_oe_nxt;
    logic [7:0] w_tx_shift_nxt;
    logic [7:0] w_rx_data_nxt;
    logic       w_rx_valid_nxt;
    logic       w_tx_req_nxt;
    logic       w_addressed_nxt;
    logic       w_stop_det_nxt;
    logic [7:0] w_shift_in;
    logic       w_addr_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl        = r_scl_sync[SYNC_STAGES-1];
    assign w_sda        = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise   = w_scl & ~r_scl_d;
    assign w_scl_fall   = ~w_scl & r_scl_d;
    assign w_start      = w_scl & r_sda_d & ~w_sda;
    assign w_stop       = w_scl & ~r_sda_d & w_sda;
    assign w_shift_in   = {r_shift[6:0], w_sda};
    // General call (address 0) is never answered, whatever SLAVE_ADDR is.
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR) && (r_shift[7:1] != 7'd0);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'd0;
            r_cnt       <= 3'd7;
            r_full      <= 1'b0;
            r_rw        <= 1'b0;
            r_ack       <= 1'b0;
            r_oe        <= 1'b0;
            r_tx_shift  <= 8'd0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_addressed <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_full      <= w_full_nxt;
            r_rw        <= w_rw_nxt;
            r_ack       <= w_ack_nxt;
            r_oe        <= w_oe_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_req    <= w_tx_req_nxt;
            r_addressed <= w_addressed_nxt;
            r_stop_det  <= w_stop_det_nxt;
        end
    end

    // Next state: bus conditions override every protocol step.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_ADDR;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:
                    if (w_scl_fall && r_full)
                        w_state_nxt = w_addr_match ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK:
                    if (w_scl_fall)
                        w_state_nxt = r_rw ? S_RD_BYTE : S_WR_BYTE;
                S_WR_BYTE:
                    if (w_scl_fall && r_full)
                        w_state_nxt = S_WR_ACK;
                S_WR_ACK:
                    if (w_scl_fall)
                        w_state_nxt = r_ack ? S_WR_BYTE : S_IGNORE;
                S_RD_BYTE:
                    if (w_scl_fall && (r_cnt == 3'd0))
                        w_state_nxt = S_RD_ACK;
                S_RD_ACK:
                    if (w_scl_rise && w_sda)
                        w_state_nxt = S_IGNORE;
                    else if (w_scl_fall && r_full)
                        w_state_nxt = S_RD_BYTE;
                default: ;
            endcase
        end
    end

    // Datapath and output next values; SDA drive only changes on scl_fall.
    always_comb begin
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_full_nxt      = r_full;
        w_rw_nxt        = r_rw;
        w_ack_nxt       = r_ack;
        w_oe_nxt        = r_oe;
        w_tx_shift_nxt  = r_tx_shift;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_tx_req_nxt    = 1'b0;
        w_addressed_nxt = r_addressed;
        w_stop_det_nxt  = 1'b0;
        if (w_start || w_stop) begin
            w_cnt_nxt       = 3'd7;
            w_full_nxt      = 1'b0;
            w_oe_nxt        = 1'b0;
            w_addressed_nxt = 1'b0;
            w_stop_det_nxt  = w_stop;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_shift_in;
                        if (r_cnt == 3'd0) w_full_nxt = 1'b1;
                        else               w_cnt_nxt  = r_cnt - 3'd1;
                    end else if (w_scl_fall && r_full && w_addr_match) begin
                        w_oe_nxt = 1'b1;
                        w_rw_nxt = r_shift[0];
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_addressed_nxt = 1'b1;
                        w_cnt_nxt       = 3'd7;
                        w_full_nxt      = 1'b0;
                        if (r_rw) begin
                            w_tx_shift_nxt = tx_data;
                            w_tx_req_nxt   = 1'b1;
                            w_oe_nxt       = ~tx_data[7];
                        end else begin
                            w_oe_nxt = 1'b0;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_shift_in;
                        if (r_cnt == 3'd0) begin
                            w_full_nxt     = 1'b1;
                            w_rx_data_nxt  = w_shift_in;
                            w_rx_valid_nxt = 1'b1;
                            w_ack_nxt      = rx_ready;
                        end else begin
                            w_cnt_nxt = r_cnt - 3'd1;
                        end
                    end else if (w_scl_fall && r_full) begin
                        w_oe_nxt = r_ack;
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_nxt   = 1'b0;
                        w_cnt_nxt  = 3'd7;
                        w_full_nxt = 1'b0;
                        if (!r_ack) w_addressed_nxt = 1'b0;
                    end
                end
                S_RD_BYTE: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 3'd0) begin
                            w_oe_nxt   = 1'b0;
                            w_full_nxt = 1'b0;
                        end else begin
                            w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
                            w_oe_nxt       = ~r_tx_shift[6];
                            w_cnt_nxt      = r_cnt - 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    // r_full marks "master ACK seen" while waiting for the fall.
                    if (w_scl_rise) begin
                        if (w_sda) w_addressed_nxt = 1'b0;
                        else       w_full_nxt      = 1'b1;
                    end else if (w_scl_fall && r_full) begin
                        w_tx_shift_nxt = tx_data;
                        w_tx_req_nxt   = 1'b1;
                        w_oe_nxt       = ~tx_data[7];
                        w_cnt_nxt      = 3'd7;
                        w_full_nxt     = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDA       = r_oe ? 1'b0 : 1'bz;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_req    = r_tx_req;
    assign addressed = r_addressed;
    assign stop_det  = r_stop_det;
    assign state_out = r_state;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master drives SCL/SDA and
// immediate assertions check ACKs, read data, pulses and FSM state.
module tb_i2c_slave;

  localparam int Q = 50;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IGNORE = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       rx_ready = 1'b1;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       addressed;
  logic       stop_det;
  logic [2:0] state_out;

  int n_assert = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int stop_cnt = 0;
  int low_cnt = 0;
  logic [7:0] rx_q[$];

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  // clock / reset block
  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .SCL       (scl),
    .SDA       (sda),
    .tx_data   (tx_data),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_req    (tx_req),
    .addressed (addressed),
    .stop_det  (stop_det),
    .state_out (state_out)
  );

  // pulse monitors, sampled on the inactive edge
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_req) tx_cnt++;
    if (stop_det) stop_cnt++;
    if (sda === 1'b0 && m_sda) low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wbit(input logic b);
    m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    ack = ~b;
  endtask

  task automatic rbits(input int n, output logic [7:0] d);
    logic b;
    d = 8'd0;
    for (int i = 0; i < n; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         rx_b, tx_b, st_b, lo_b, q_b;
    logic [7:0] rst_tx[2];

    // reset state
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(state_out), 32'(ST_IDLE));
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_pulses", {29'd0, rx_valid, tx_req, stop_det}, 32'h0);
    check("reset_addressed", 32'(addressed), 32'h0);
    check("reset_sda", 32'(sda), 32'h1);
    #(2*Q);

    // write 0xA5, 0x3C to 0x42
    rx_b = rx_cnt; st_b = stop_cnt; q_b = rx_q.size();
    bus_start();
    wbyte(8'h84, ack); check("wr_addr_ack", 32'(ack), 32'h1);
    check("wr_addressed", 32'(addressed), 32'h1);
    wbyte(8'hA5, ack); check("wr_d0_ack", 32'(ack), 32'h1);
    wbyte(8'h3C, ack); check("wr_d1_ack", 32'(ack), 32'h1);
    bus_stop();
    check("wr_rx_cnt", 32'(rx_cnt - rx_b), 32'd2);
    check("wr_rx_byte0", 32'(rx_q[q_b]), 32'hA5);
    check("wr_rx_byte1", 32'(rx_q[q_b + 1]), 32'h3C);
    check("wr_stop_det", 32'(stop_cnt - st_b), 32'd1);
    check("wr_addressed_end", 32'(addressed), 32'h0);
    check("wr_state_end", 32'(state_out), 32'(ST_IDLE));

    // read 0x5A (ACK) then 0xC3 (NACK)
    tx_b = tx_cnt; tx_data = 8'h5A;
    bus_start();
    wbyte(8'h85, ack); check("rd_addr_ack", 32'(ack), 32'h1);
    rbits(8, d); check("rd_byte0", 32'(d), 32'h5A);
    tx_data = 8'hC3;
    wbit(1'b0);
    rbits(8, d); check("rd_byte1", 32'(d), 32'hC3);
    wbit(1'b1);
    check("rd_tx_req_cnt", 32'(tx_cnt - tx_b), 32'd2);
    check("rd_state_ignore", 32'(state_out), 32'(ST_IGNORE));
    check("rd_sda_released", 32'(sda), 32'h1);
    bus_stop();
    check("rd_state_end", 32'(state_out), 32'(ST_IDLE));

    // foreign address 0x48
    rx_b = rx_cnt; lo_b = low_cnt;
    bus_start();
    wbyte(8'h90, ack); check("na_addr_nack", 32'(ack), 32'h0);
    wbyte(8'h12, ack);
    check("na_state_ignore", 32'(state_out), 32'(ST_IGNORE));
    check("na_never_low", 32'(low_cnt - lo_b), 32'd0);
    check("na_rx_cnt", 32'(rx_cnt - rx_b), 32'd0);
    bus_stop();
    check("na_state_end", 32'(state_out), 32'(ST_IDLE));

    // rx_ready low: first data byte NACKed
    rx_ready = 1'b0; rx_b = rx_cnt;
    bus_start();
    wbyte(8'h84, ack); check("nr_addr_ack", 32'(ack), 32'h1);
    wbyte(8'h55, ack); check("nr_d0_nack", 32'(ack), 32'h0);
    check("nr_rx_data", 32'(rx_data), 32'h55);
    check("nr_state_ignore", 32'(state_out), 32'(ST_IGNORE));
    check("nr_addressed", 32'(addressed), 32'h0);
    wbyte(8'h66, ack); check("nr_d1_nack", 32'(ack), 32'h0);
    check("nr_rx_cnt", 32'(rx_cnt - rx_b), 32'd1);
    bus_stop();
    rx_ready = 1'b1;

    // repeated START after 4 data bits, then read
    rx_b = rx_cnt; tx_b = tx_cnt; tx_data = 8'h96;
    bus_start();
    wbyte(8'h84, ack); check("rs_addr_ack", 32'(ack), 32'h1);
    for (int i = 0; i < 4; i++) wbit(1'b1);
    bus_start();
    check("rs_addressed_clr", 32'(addressed), 32'h0);
    wbyte(8'h85, ack); check("rs_rd_addr_ack", 32'(ack), 32'h1);
    check("rs_tx_req", 32'(tx_cnt - tx_b), 32'd1);
    rbits(8, d); check("rs_rd_byte", 32'(d), 32'h96);
    wbit(1'b1);
    bus_stop();
    check("rs_no_rx", 32'(rx_cnt - rx_b), 32'd0);

    // reset during read bit 3, then recovery
    rst_tx[0] = 8'hFF;
    rst_tx[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      tx_data = rst_tx[k];
      bus_start();
      wbyte(8'h85, ack); check("rr_addr_ack", 32'(ack), 32'h1);
      rbits(4, d); check("rr_hi_nibble", 32'(d[3:0]), 32'(rst_tx[k][7:4]));
      m_sda = 1'b1; #Q; scl = 1'b1; #Q;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      check("rr_sda_released", 32'(sda), 32'h1);
      check("rr_state", 32'(state_out), 32'(ST_IDLE));
      check("rr_outputs", {20'd0, rx_data, addressed, rx_valid, tx_req, stop_det}, 32'h0);
      rst = 1'b0;
      #Q; scl = 1'b0; #Q;
      bus_start();
      wbyte(8'h84, ack); check("rr_recover_ack", 32'(ack), 32'h1);
      wbyte(8'h11, ack); check("rr_recover_d_ack", 32'(ack), 32'h1);
      check("rr_recover_rx", 32'(rx_data), 32'h11);
      bus_stop();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
